console_fifo_arb: RTL

Multi-channel byte buffer for the console multiplexer. Each of CHANNELS input sources has its own synchronous FIFO. A round-robin arbiter drains all FIFOs into a single registered output stream, and each output word carries its source channel index. This block is the parametrised successor to the single-channel FIFO. It adds per-channel occupancy, a valid/ready handshake on both sides, sticky overflow flags, and optional line-atomic arbitration.

---
 rtl/console_fifo_arb.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/console_fifo_arb.sv
// console_fifo_arb
//
// Multi-channel byte buffer for the console multiplexer. Each input channel
// owns a small synchronous FIFO. A round-robin arbiter drains the FIFOs into
// one registered output stream, and each output word is tagged with its
// source channel.
//
// Optional build macro: CONSOLE_FIFO_LINE_LOCK_EN
//   When defined, the arbiter stays on a channel once it wins. It releases
//   after that channel delivers a newline (low byte 8'h0A) or after the
//   channel stays empty for LOCK_TIMEOUT consecutive cycles. The
//   LOCK_TIMEOUT parameter exists only in that build.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   in_valid     per-channel write request
//   in_data      per-channel write data, channel i at [i*WIDTH +: WIDTH]
//   in_ready     per-channel not-full, decoded from state only
//   out_valid    registered output word valid
//   out_data     registered output word
//   out_chan     registered source channel of out_data
//   out_ready    downstream accepts the current word
//   ch_count     per-channel occupancy, 0..DEPTH, $clog2(DEPTH)+1 bits each
//   ch_overflow  sticky per-channel flag: write attempted while full

module console_fifo_arb #(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8
`ifdef CONSOLE_FIFO_LINE_LOCK_EN
    ,
    parameter int LOCK_TIMEOUT = 255
`endif
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [CHANNELS-1:0]                    in_valid,
    input  logic [CHANNELS*WIDTH-1:0]              in_data,
    output logic [CHANNELS-1:0]                    in_ready,
    output logic                                   out_valid,
    output logic [WIDTH-1:0]                       out_data,
    output logic [((CHANNELS > 2) ? $clog2(CHANNELS) : 1)-1:0] out_chan,
    input  logic                                   out_ready,
    output logic [CHANNELS*($clog2(DEPTH)+1)-1:0]  ch_count,
    output logic [CHANNELS-1:0]                    ch_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

    logic [WIDTH-1:0]    mem    [CHANNELS][DEPTH];
    logic [PW-1:0]       wr_ptr [CHANNELS];
    logic [PW-1:0]       rd_ptr [CHANNELS];
    logic [CHANNELS-1:0] empty;
    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] wr_en;
    logic [CW-1:0]       last_grant;
    logic [CW-1:0]       rr_winner;
    logic                rr_found;
    logic [CW-1:0]       grant_chan;
    logic                grant_valid;
    logic                load;
    logic [WIDTH-1:0]    head_data;

    // Extra pointer MSB separates full from empty, so all DEPTH slots are usable.
    always_comb begin
        empty    = '0;
        full     = '0;
        wr_en    = '0;
        in_ready = '0;
        ch_count = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            empty[i]    = (wr_ptr[i] == rd_ptr[i]);
            full[i]     = (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]) &&
                          (wr_ptr[i][AW] != rd_ptr[i][AW]);
            in_ready[i] = !full[i];
            wr_en[i]    = in_valid[i] && !full[i];
            ch_count[i*PW +: PW] = wr_ptr[i] - rd_ptr[i];
        end
    end

    // Round-robin search starting one past the previous winner.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            if (!rr_found && !empty[(int'(last_grant) + k) % CHANNELS]) begin
                rr_found  = 1'b1;
                rr_winner = CW'((int'(last_grant) + k) % CHANNELS);
            end
        end
    end

`ifdef CONSOLE_FIFO_LINE_LOCK_EN
    localparam int IW = ($clog2(LOCK_TIMEOUT + 1) > 8) ? $clog2(LOCK_TIMEOUT + 1) : 8;

    logic          locked;
    logic [CW-1:0] lock_chan;
    logic [IW-1:0] idle_cnt;

    // A locked channel blocks everyone else, even while it has nothing to send.
    assign grant_valid = locked ? !empty[lock_chan] : rr_found;
    assign grant_chan  = locked ? lock_chan : rr_winner;

    always_ff @(posedge clk) begin
        if (rst) begin
            locked    <= 1'b0;
            lock_chan <= '0;
            idle_cnt  <= '0;
        end else if (load) begin
            idle_cnt <= '0;
            if (head_data[7:0] == 8'h0A) begin
                locked <= 1'b0;
            end else begin
                locked    <= 1'b1;
                lock_chan <= grant_chan;
            end
        end else if (locked && empty[lock_chan]) begin
            if (idle_cnt == IW'(LOCK_TIMEOUT - 1)) begin
                locked   <= 1'b0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    assign grant_valid = rr_found;
    assign grant_chan  = rr_winner;
`endif

    assign head_data = mem[grant_chan][rd_ptr[grant_chan][AW-1:0]];
    assign load      = grant_valid && (!out_valid || out_ready);

    // Storage has no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en[i]) begin
                    mem[i][wr_ptr[i][AW-1:0]] <= in_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Pointer and overflow bookkeeping. A read and a write on one channel can
    // happen together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            ch_overflow <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (in_valid[i] && full[i]) begin
                    ch_overflow[i] <= 1'b1;
                end
                if (load && (grant_chan == CW'(i))) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
            end
        end
    end

    // Single output slot. It refills on the same edge that it hands off, and
    // it stays unchanged while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            last_grant <= CW'(CHANNELS - 1);
        end else if (load) begin
            out_valid  <= 1'b1;
            out_data   <= head_data;
            out_chan   <= grant_chan;
            last_grant <= grant_chan;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
